dlx_pipeline: RTL and testbench
===============================

Name: dlx_pipeline

Overview:
- 5-stage in-order 32-bit integer pipeline (IF, ID, EX, MEM, WB) with a MIPS-style encoding, byte-addressed and big-endian.
- Fetches from an external combinational instruction memory (imem) and accesses an external data memory (dmem).
  - dmem read is combinational and returns the aligned word.
  - dmem write is synchronous and byte-enabled by dataSize.
- Top-level CPU core; the bench or SoC wires imem and dmem around it.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pcSelector  in  1  1 = PC loads startAddress on the next clock edge.
- startAddress  in  32  restart address.
- unshiftedMemDataUnsigned  in  32  aligned data word from dmem at {aluResultMem[31:2],2'b00}.
- instruction  in  32  imem word at currentAddress.
- currentAddress  out  32  IF-stage PC.
- aluResultMem  out  32  MEM-stage effective address / ALU result.
- busBMem2  out  32  MEM-stage store data, right-justified; dmem lane-shifts it.
- memWr  out  1  MEM-stage store strobe.
- dataSize  out  2  access size: 00 byte, 01 half, 11 word (10 treated as word).

Behaviour:
- Reset (rst_n=0, async):
  - PC=RESET_PC.
  - All pipeline registers hold a NOP; memWr=0, dataSize=11, aluResultMem=0, busBMem2=0.
  - All 32 registers = 0.
- Priority at a clock edge: reset > pcSelector > branch redirect > load-use stall > PC+4.
- pcSelector=1 at an edge:
  - PC<=startAddress.
  - IF/ID and ID/EX become NOP.
  - Older instructions in EX/MEM/WB complete.
- Encoding: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm16[15:0] sign-extended.
- R-type (op 00), rd<=f(rs,rt):
  - ADD 20, SUB 22, AND 24, OR 25, XOR 26, SLT 2A (signed, result 0/1).
  - Arithmetic wraps mod 2^32; no overflow trap.
- I-type, rt<=f(rs,imm):
  - ADDI 08.
  - ANDI 0C, ORI 0D: both zero-extend the immediate.
- Loads, EA=rs+sext(imm):
  - LB 20, LH 21, LW 23, LBU 24, LHU 25.
  - Byte lane: EA[1:0]=0 selects bits[31:24].
  - Halfword: EA[1]=0 selects [31:16].
  - Misaligned LH/LW ignore the low EA bits.
- Stores: SB 28, SH 29, SW 2B.
  - memWr=1 for exactly one cycle while the store is in MEM.
  - busBMem2 = rt value.
- Branches, resolved in EX, no delay slot, taken → flush IF/ID and ID/EX:
  - BEQZ 04: taken if rs==0, target PC+4+sext(imm).
  - BNEZ 05: taken if rs!=0, same target.
  - J 02: target PC+4+sext(imm26).
- Undefined op/funct execute as NOP. Register r0 reads 0 and ignores writes.
- Forwarding into EX, priority EX/MEM > MEM/WB > register file.
- Register file writes in WB; an ID read of the same register in the same cycle returns the new value (write-through).
- Load-use: an instruction in ID that uses the rt of a load in EX stalls 1 cycle (PC and IF/ID hold, ID/EX gets a NOP); the value is then forwarded from MEM/WB.
- Latency: an ALU result is usable by the immediately following instruction (0 bubbles). Taken-branch penalty is 2 cycles.

Decomposition:
- Package dlx_pkg:
  - Opcode and funct constants.
  - dataSize codes.
  - ALU-op enum.
  - NOP constant.
- Natural sub-modules:
  - dlx_regfile: 32x32, async reset, write-through.
  - dlx_alu.
- Hazard/forward logic stays inline in dlx_pipeline.
- dmem and imem are separate existing blocks, not part of this RTL.

Test Plan:
- Reset then pcSelector=1 with startAddress=0x40 for one edge → currentAddress=0x40 on the following cycle, then 0x44, 0x48.
- ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; SW r3,0(r0) → cycle with memWr=1, aluResultMem=0, busBMem2=12, dataSize=11 (exercises back-to-back forwarding).
- dmem word 0 = 0x80FF1234:
  - LB 0 gives 0xFFFFFF80; LBU 1 gives 0x000000FF; LH 2 gives 0x00001234; LW 0 gives 0x80FF1234.
  - Each checked via a following SW of the result.
- LW r4,0(r0) followed immediately by ADD r5,r4,r4 → exactly one stall cycle (currentAddress holds); stored r5 = 2× the loaded word mod 2^32.
- BNEZ r1,+8 with r1=5 → the two fall-through instructions never store (memWr stays 0 for them); the instruction at the target executes. BEQZ with r1=5 → no redirect.
- Assert rst_n low mid-program → outputs and PC return to reset values immediately; no memWr pulse is produced after deassertion until a store reaches MEM.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared encodings, control bundles and pipeline-register layouts for the
// five-stage DLX core.
package dlx_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQZ  = 6'h04;
   localparam logic [5:0] OP_BNEZ  = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_XOR = 6'h26;
   localparam logic [5:0] F_SLT = 6'h2A;

   localparam logic [1:0] DS_BYTE = 2'b00;
   localparam logic [1:0] DS_HALF = 2'b01;
   localparam logic [1:0] DS_WORD = 2'b11;

   // op 00 / funct 00 is undefined and therefore executes as a bubble
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT
   } alu_op_e;

   typedef enum logic [1:0] {
      BR_NONE, BR_BEQZ, BR_BNEZ, BR_JUMP
   } branch_e;

   typedef struct packed {
      alu_op_e    aluOp;
      logic       useImm;
      logic       regWrite;
      logic       memRead;
      logic       memWrite;
      logic       loadSigned;
      logic [1:0] dataSize;
      branch_e    branch;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{aluOp: ALU_ADD, useImm: 1'b0, regWrite: 1'b0,
                                  memRead: 1'b0, memWrite: 1'b0, loadSigned: 1'b0,
                                  dataSize: DS_WORD, branch: BR_NONE};

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } ifid_t;

   typedef struct packed {
      ctrl_t       ctrl;
      logic [31:0] rsVal;
      logic [31:0] rtVal;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [4:0]  rsIdx;
      logic [4:0]  rtIdx;
      logic [4:0]  destIdx;
   } idex_t;

   typedef struct packed {
      logic        regWrite;
      logic        memRead;
      logic        memWrite;
      logic        loadSigned;
      logic [1:0]  dataSize;
      logic [31:0] aluResult;
      logic [31:0] storeData;
      logic [4:0]  destIdx;
   } exmem_t;

   typedef struct packed {
      logic        regWrite;
      logic [31:0] wbValue;
      logic [4:0]  destIdx;
   } memwb_t;

   localparam ifid_t IFID_NOP = '{instr: NOP_INSTR, pc4: 32'h0};

   localparam idex_t IDEX_NOP = '{ctrl: CTRL_NOP, rsVal: 32'h0, rtVal: 32'h0, imm: 32'h0,
                                  pc4: 32'h0, rsIdx: 5'd0, rtIdx: 5'd0, destIdx: 5'd0};

   localparam exmem_t EXMEM_NOP = '{regWrite: 1'b0, memRead: 1'b0, memWrite: 1'b0,
                                    loadSigned: 1'b0, dataSize: DS_WORD, aluResult: 32'h0,
                                    storeData: 32'h0, destIdx: 5'd0};

   localparam memwb_t MEMWB_NOP = '{regWrite: 1'b0, wbValue: 32'h0, destIdx: 5'd0};

   // Big-endian lane pick from the aligned dmem word: offset 0 is bits [31:24]
   function automatic logic [31:0] extractLoad(input logic [31:0] word,
                                               input logic [1:0]  addrLow,
                                               input logic [1:0]  size,
                                               input logic        signExt);
      logic [7:0]  lane8;
      logic [15:0] lane16;
      case (addrLow)
         2'd0:    lane8 = word[31:24];
         2'd1:    lane8 = word[23:16];
         2'd2:    lane8 = word[15:8];
         default: lane8 = word[7:0];
      endcase
      lane16 = addrLow[1] ? word[15:0] : word[31:16];
      case (size)
         DS_BYTE: return signExt ? {{24{lane8[7]}}, lane8} : {24'h0, lane8};
         DS_HALF: return signExt ? {{16{lane16[15]}}, lane16} : {16'h0, lane16};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/dlx_alu.sv
// Integer ALU for the EX stage; arithmetic wraps mod 2^32, SLT is signed.
module dlx_alu
   import dlx_pkg::*;
(
   input  alu_op_e     op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] result_o
);

   always_comb begin
      case (op_i)
         ALU_SUB: result_o = a_i - b_i;
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_XOR: result_o = a_i ^ b_i;
         ALU_SLT: result_o = {31'h0, ($signed(a_i) < $signed(b_i))};
         default: result_o = a_i + b_i;
      endcase
   end

endmodule

// File: rtl/dlx_regfile.sv
// 32x32 register file; r0 is hardwired to zero and a same-cycle write is
// visible on the read ports.
module dlx_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddrA_i,
   output logic [31:0] rdataA_o,
   input  logic [4:0]  raddrB_i,
   output logic [31:0] rdataB_o
);

   logic [31:0] regs_q [32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 32'h0;
         end
      end else if (we_i && (waddr_i != 5'd0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      if (raddrA_i == 5'd0) begin
         rdataA_o = 32'h0;
      end else if (we_i && (waddr_i == raddrA_i)) begin
         rdataA_o = wdata_i;
      end else begin
         rdataA_o = regs_q[raddrA_i];
      end
   end

   always_comb begin
      if (raddrB_i == 5'd0) begin
         rdataB_o = 32'h0;
      end else if (we_i && (waddr_i == raddrB_i)) begin
         rdataB_o = wdata_i;
      end else begin
         rdataB_o = regs_q[raddrB_i];
      end
   end

endmodule

// File: rtl/dlx_pipeline.sv
// Five-stage in-order DLX core with EX-stage branch resolution, full
// forwarding into EX and a one-cycle load-use interlock.
module dlx_pipeline
   import dlx_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pcSelector,
   input  logic [31:0] startAddress,
   input  logic [31:0] unshiftedMemDataUnsigned,
   input  logic [31:0] instruction,
   output logic [31:0] currentAddress,
   output logic [31:0] aluResultMem,
   output logic [31:0] busBMem2,
   output logic        memWr,
   output logic [1:0]  dataSize
);

   logic [31:0] pc_q, pc_d;
   ifid_t       ifid_q, ifid_d;
   idex_t       idex_q, idex_d, idexDecoded;
   exmem_t      exmem_q, exmem_d;
   memwb_t      memwb_q, memwb_d;

   logic [5:0]  opcode, funct;
   logic [4:0]  rsIdx, rtIdx, rdIdx;
   logic [15:0] imm16;
   ctrl_t       idCtrl;
   logic [4:0]  idDest;
   logic [31:0] idImm;
   logic        usesRs, usesRt;
   logic [31:0] rfRsData, rfRtData;
   logic        loadUseStall;

   logic [31:0] fwdA, fwdB, aluB, aluOut, branchTarget, loadValue, pcPlus4;
   logic        branchTaken;

   assign opcode  = ifid_q.instr[31:26];
   assign rsIdx   = ifid_q.instr[25:21];
   assign rtIdx   = ifid_q.instr[20:16];
   assign rdIdx   = ifid_q.instr[15:11];
   assign funct   = ifid_q.instr[5:0];
   assign imm16   = ifid_q.instr[15:0];
   assign pcPlus4 = pc_q + 32'd4;

   dlx_regfile u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (memwb_q.regWrite),
      .waddr_i  (memwb_q.destIdx),
      .wdata_i  (memwb_q.wbValue),
      .raddrA_i (rsIdx),
      .rdataA_o (rfRsData),
      .raddrB_i (rtIdx),
      .rdataB_o (rfRtData)
   );

   always_comb begin
      idCtrl = CTRL_NOP;
      idDest = 5'd0;
      idImm  = {{16{imm16[15]}}, imm16};
      usesRs = 1'b0;
      usesRt = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            idDest          = rdIdx;
            usesRs          = 1'b1;
            usesRt          = 1'b1;
            idCtrl.regWrite = 1'b1;
            case (funct)
               F_ADD:   idCtrl.aluOp = ALU_ADD;
               F_SUB:   idCtrl.aluOp = ALU_SUB;
               F_AND:   idCtrl.aluOp = ALU_AND;
               F_OR:    idCtrl.aluOp = ALU_OR;
               F_XOR:   idCtrl.aluOp = ALU_XOR;
               F_SLT:   idCtrl.aluOp = ALU_SLT;
               default: idCtrl.regWrite = 1'b0;
            endcase
         end
         OP_ADDI, OP_ANDI, OP_ORI: begin
            idDest          = rtIdx;
            usesRs          = 1'b1;
            idCtrl.useImm   = 1'b1;
            idCtrl.regWrite = 1'b1;
            if (opcode == OP_ANDI) begin
               idCtrl.aluOp = ALU_AND;
               idImm        = {16'h0, imm16};
            end else if (opcode == OP_ORI) begin
               idCtrl.aluOp = ALU_OR;
               idImm        = {16'h0, imm16};
            end
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            idDest            = rtIdx;
            usesRs            = 1'b1;
            idCtrl.useImm     = 1'b1;
            idCtrl.regWrite   = 1'b1;
            idCtrl.memRead    = 1'b1;
            idCtrl.loadSigned = (opcode == OP_LB) || (opcode == OP_LH);
            if ((opcode == OP_LB) || (opcode == OP_LBU)) begin
               idCtrl.dataSize = DS_BYTE;
            end else if ((opcode == OP_LH) || (opcode == OP_LHU)) begin
               idCtrl.dataSize = DS_HALF;
            end
         end
         OP_SB, OP_SH, OP_SW: begin
            usesRs          = 1'b1;
            usesRt          = 1'b1;
            idCtrl.useImm   = 1'b1;
            idCtrl.memWrite = 1'b1;
            if (opcode == OP_SB) begin
               idCtrl.dataSize = DS_BYTE;
            end else if (opcode == OP_SH) begin
               idCtrl.dataSize = DS_HALF;
            end
         end
         OP_BEQZ: begin
            usesRs        = 1'b1;
            idCtrl.branch = BR_BEQZ;
         end
         OP_BNEZ: begin
            usesRs        = 1'b1;
            idCtrl.branch = BR_BNEZ;
         end
         OP_J: begin
            idCtrl.branch = BR_JUMP;
            idImm         = {{6{ifid_q.instr[25]}}, ifid_q.instr[25:0]};
         end
         default: ;
      endcase
   end

   always_comb begin
      idexDecoded         = IDEX_NOP;
      idexDecoded.ctrl    = idCtrl;
      idexDecoded.rsVal   = rfRsData;
      idexDecoded.rtVal   = rfRtData;
      idexDecoded.imm     = idImm;
      idexDecoded.pc4     = ifid_q.pc4;
      idexDecoded.rsIdx   = rsIdx;
      idexDecoded.rtIdx   = rtIdx;
      idexDecoded.destIdx = idDest;
   end

   // A load's data only exists in MEM, so its direct consumer must wait a cycle
   assign loadUseStall = idex_q.ctrl.memRead && (idex_q.destIdx != 5'd0) &&
                         ((usesRs && (rsIdx == idex_q.destIdx)) ||
                          (usesRt && (rtIdx == idex_q.destIdx)));

   always_comb begin
      fwdA = idex_q.rsVal;
      fwdB = idex_q.rtVal;
      if (memwb_q.regWrite && (memwb_q.destIdx != 5'd0)) begin
         if (memwb_q.destIdx == idex_q.rsIdx) fwdA = memwb_q.wbValue;
         if (memwb_q.destIdx == idex_q.rtIdx) fwdB = memwb_q.wbValue;
      end
      if (exmem_q.regWrite && !exmem_q.memRead && (exmem_q.destIdx != 5'd0)) begin
         if (exmem_q.destIdx == idex_q.rsIdx) fwdA = exmem_q.aluResult;
         if (exmem_q.destIdx == idex_q.rtIdx) fwdB = exmem_q.aluResult;
      end
   end

   assign aluB = idex_q.ctrl.useImm ? idex_q.imm : fwdB;

   dlx_alu u_alu (
      .op_i     (idex_q.ctrl.aluOp),
      .a_i      (fwdA),
      .b_i      (aluB),
      .result_o (aluOut)
   );

   assign branchTarget = idex_q.pc4 + idex_q.imm;

   always_comb begin
      case (idex_q.ctrl.branch)
         BR_BEQZ: branchTaken = (fwdA == 32'h0);
         BR_BNEZ: branchTaken = (fwdA != 32'h0);
         BR_JUMP: branchTaken = 1'b1;
         default: branchTaken = 1'b0;
      endcase
   end

   always_comb begin
      exmem_d            = EXMEM_NOP;
      exmem_d.regWrite   = idex_q.ctrl.regWrite;
      exmem_d.memRead    = idex_q.ctrl.memRead;
      exmem_d.memWrite   = idex_q.ctrl.memWrite;
      exmem_d.loadSigned = idex_q.ctrl.loadSigned;
      exmem_d.dataSize   = idex_q.ctrl.dataSize;
      exmem_d.aluResult  = aluOut;
      exmem_d.storeData  = fwdB;
      exmem_d.destIdx    = idex_q.destIdx;
   end

   assign loadValue = extractLoad(unshiftedMemDataUnsigned, exmem_q.aluResult[1:0],
                                  exmem_q.dataSize, exmem_q.loadSigned);

   always_comb begin
      memwb_d.regWrite = exmem_q.regWrite;
      memwb_d.wbValue  = exmem_q.memRead ? loadValue : exmem_q.aluResult;
      memwb_d.destIdx  = exmem_q.destIdx;
   end

   // Front-end steering: restart beats redirect beats interlock beats PC+4
   always_comb begin
      pc_d   = pcPlus4;
      ifid_d = '{instr: instruction, pc4: pcPlus4};
      idex_d = idexDecoded;
      if (pcSelector) begin
         pc_d   = startAddress;
         ifid_d = IFID_NOP;
         idex_d = IDEX_NOP;
      end else if (branchTaken) begin
         pc_d   = branchTarget;
         ifid_d = IFID_NOP;
         idex_d = IDEX_NOP;
      end else if (loadUseStall) begin
         pc_d   = pc_q;
         ifid_d = ifid_q;
         idex_d = IDEX_NOP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         ifid_q  <= IFID_NOP;
         idex_q  <= IDEX_NOP;
         exmem_q <= EXMEM_NOP;
         memwb_q <= MEMWB_NOP;
      end else begin
         pc_q    <= pc_d;
         ifid_q  <= ifid_d;
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

   assign currentAddress = pc_q;
   assign aluResultMem   = exmem_q.aluResult;
   assign busBMem2       = exmem_q.storeData;
   assign memWr          = exmem_q.memWrite;
   assign dataSize       = exmem_q.dataSize;

endmodule

// File: tb/tb_dlx_pipeline.sv
// Self-checking bench for dlx_pipeline: small programs run from a bench imem,
// and every store seen in MEM is matched against a scoreboard queue.
module tb_dlx_pipeline;
   import dlx_pkg::*;

   typedef logic [31:0] prog_t [8];

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
   } store_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [4:0]  storeReg;
      logic [31:0] expected;
   } vec_t;

   localparam int NUM_VECS = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pcSelector;
   logic [31:0] startAddress;
   logic [31:0] unshiftedMemDataUnsigned;
   logic [31:0] instruction;
   logic [31:0] currentAddress;
   logic [31:0] aluResultMem;
   logic [31:0] busBMem2;
   logic        memWr;
   logic [1:0]  dataSize;

   logic [31:0] imem [64];
   logic [31:0] dmem [64];
   logic [31:0] dmemWord0;

   store_t sbQ[$];
   vec_t   vecs [NUM_VECS];
   int     checks   = 0;
   int     failures = 0;

   dlx_pipeline #(.RESET_PC(32'h0000_0000)) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .pcSelector               (pcSelector),
      .startAddress             (startAddress),
      .unshiftedMemDataUnsigned (unshiftedMemDataUnsigned),
      .instruction              (instruction),
      .currentAddress           (currentAddress),
      .aluResultMem             (aluResultMem),
      .busBMem2                 (busBMem2),
      .memWr                    (memWr),
      .dataSize                 (dataSize)
   );

   always #5 clk = ~clk;

   // Combinational imem / dmem read; anything beyond 256 bytes reads as NOP / zero
   assign instruction = (currentAddress < 32'd256) ? imem[currentAddress[7:2]] : NOP_INSTR;
   assign unshiftedMemDataUnsigned = (aluResultMem < 32'd256) ? dmem[aluResultMem[7:2]] : 32'h0;

   // dmem reloads its preset on reset and takes big-endian lane writes
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) dmem[i] <= (i == 0) ? dmemWord0 : 32'h0;
      end else if (memWr && (aluResultMem < 32'd256)) begin
         case (dataSize)
            DS_BYTE: case (aluResultMem[1:0])
               2'd0:    dmem[aluResultMem[7:2]][31:24] <= busBMem2[7:0];
               2'd1:    dmem[aluResultMem[7:2]][23:16] <= busBMem2[7:0];
               2'd2:    dmem[aluResultMem[7:2]][15:8]  <= busBMem2[7:0];
               default: dmem[aluResultMem[7:2]][7:0]   <= busBMem2[7:0];
            endcase
            DS_HALF: if (aluResultMem[1]) dmem[aluResultMem[7:2]][15:0]  <= busBMem2[15:0];
                     else                 dmem[aluResultMem[7:2]][31:16] <= busBMem2[15:0];
            default: dmem[aluResultMem[7:2]] <= busBMem2;
         endcase
      end
   end

   function automatic logic [31:0] encR(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
      return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] encJ(input logic [25:0] imm);
      return {OP_J, imm};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   task automatic pushStore(input string name, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] size);
      store_t e;
      e.name = name;
      e.addr = addr;
      e.data = data;
      e.size = size;
      sbQ.push_back(e);
   endtask

   task automatic setVec(input int i, input string name, input logic [31:0] instr,
                         input logic [4:0] storeReg, input logic [31:0] expected);
      vecs[i].name     = name;
      vecs[i].instr    = instr;
      vecs[i].storeReg = storeReg;
      vecs[i].expected = expected;
   endtask

   // Reset the core, load a fresh program, then release reset on a falling edge
   task automatic applyStimulus(input prog_t prog);
      rst_n      = 1'b0;
      pcSelector = 1'b0;
      for (int i = 0; i < 64; i++) imem[i] = (i < 8) ? prog[i] : NOP_INSTR;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs n cycles, scoring each store and counting cycles where the PC held
   task automatic runCycles(input int n, output int holds, output int stores);
      logic [31:0] prevPc;
      store_t      e;
      prevPc = currentAddress;
      holds  = 0;
      stores = 0;
      repeat (n) begin
         @(negedge clk);
         if (currentAddress == prevPc) holds++;
         prevPc = currentAddress;
         if (memWr) begin
            stores++;
            if (sbQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpectedStore actual addr=0x%08h data=0x%08h expected no store",
                        aluResultMem, busBMem2);
            end else begin
               e = sbQ.pop_front();
               checkOutput({e.name, ".addr"}, aluResultMem, e.addr);
               checkOutput({e.name, ".data"}, busBMem2, e.data);
               checkOutput({e.name, ".size"}, {30'h0, dataSize}, {30'h0, e.size});
            end
         end
      end
      checkOutput("pendingStores", 32'(sbQ.size()), 32'h0);
      sbQ.delete();
   endtask

   initial begin
      prog_t prog;
      int    holds, stores;
      bit    found;

      rst_n        = 1'b0;
      pcSelector   = 1'b0;
      startAddress = 32'h0;
      dmemWord0    = 32'h80FF_1234;
      for (int i = 0; i < 64; i++) imem[i] = NOP_INSTR;

      // Operands for the table: r1 = -3, r2 = 7, dmem word 0 = 0x80FF1234
      setVec(0,  "add",      encR(F_ADD, 5'd4, 5'd1, 5'd2),          5'd4, 32'h0000_0004);
      setVec(1,  "sub",      encR(F_SUB, 5'd4, 5'd1, 5'd2),          5'd4, 32'hFFFF_FFF6);
      setVec(2,  "and",      encR(F_AND, 5'd4, 5'd1, 5'd2),          5'd4, 32'h0000_0005);
      setVec(3,  "or",       encR(F_OR,  5'd4, 5'd1, 5'd2),          5'd4, 32'hFFFF_FFFF);
      setVec(4,  "xor",      encR(F_XOR, 5'd4, 5'd1, 5'd2),          5'd4, 32'hFFFF_FFFA);
      setVec(5,  "sltTrue",  encR(F_SLT, 5'd4, 5'd1, 5'd2),          5'd4, 32'h0000_0001);
      setVec(6,  "sltFalse", encR(F_SLT, 5'd4, 5'd2, 5'd1),          5'd4, 32'h0000_0000);
      setVec(7,  "addi",     encI(OP_ADDI, 5'd4, 5'd1, 16'hFFFF),    5'd4, 32'hFFFF_FFFC);
      setVec(8,  "andi",     encI(OP_ANDI, 5'd4, 5'd1, 16'hF0F0),    5'd4, 32'h0000_F0F0);
      setVec(9,  "ori",      encI(OP_ORI,  5'd4, 5'd2, 16'h8000),    5'd4, 32'h0000_8007);
      setVec(10, "lb0",      encI(OP_LB,   5'd4, 5'd0, 16'h0000),    5'd4, 32'hFFFF_FF80);
      setVec(11, "lbu1",     encI(OP_LBU,  5'd4, 5'd0, 16'h0001),    5'd4, 32'h0000_00FF);
      setVec(12, "lh2",      encI(OP_LH,   5'd4, 5'd0, 16'h0002),    5'd4, 32'h0000_1234);
      setVec(13, "lw0",      encI(OP_LW,   5'd4, 5'd0, 16'h0000),    5'd4, 32'h80FF_1234);
      setVec(14, "lhu0",     encI(OP_LHU,  5'd4, 5'd0, 16'h0000),    5'd4, 32'h0000_80FF);
      setVec(15, "lb3",      encI(OP_LB,   5'd4, 5'd0, 16'h0003),    5'd4, 32'h0000_0034);
      setVec(16, "lwMisal",  encI(OP_LW,   5'd4, 5'd0, 16'h0003),    5'd4, 32'h80FF_1234);
      setVec(17, "undefFn",  encR(6'h3F, 5'd4, 5'd1, 5'd2),          5'd4, 32'h0000_0000);
      setVec(18, "r0Write",  encI(OP_ADDI, 5'd0, 5'd2, 16'h0009),    5'd0, 32'h0000_0000);
      setVec(19, "lh0",      encI(OP_LH,   5'd4, 5'd0, 16'h0000),    5'd4, 32'hFFFF_80FF);

      // Reset state, sampled while reset is held
      @(negedge clk);
      checkOutput("resetPc",      currentAddress, 32'h0);
      checkOutput("resetMemWr",   {31'h0, memWr}, 32'h0);
      checkOutput("resetSize",    {30'h0, dataSize}, {30'h0, DS_WORD});
      checkOutput("resetAluRes",  aluResultMem, 32'h0);
      checkOutput("resetBusB",    busBMem2, 32'h0);
      rst_n = 1'b1;

      // Restart through pcSelector
      @(negedge clk);
      pcSelector   = 1'b1;
      startAddress = 32'h40;
      @(negedge clk);
      pcSelector = 1'b0;
      checkOutput("pcSel0", currentAddress, 32'h40);
      @(negedge clk);
      checkOutput("pcSel1", currentAddress, 32'h44);
      @(negedge clk);
      checkOutput("pcSel2", currentAddress, 32'h48);

      for (int v = 0; v < NUM_VECS; v++) begin
         prog = '{encI(OP_ADDI, 5'd1, 5'd0, 16'hFFFD), encI(OP_ADDI, 5'd2, 5'd0, 16'h0007),
                  vecs[v].instr, encI(OP_SW, vecs[v].storeReg, 5'd0, 16'h0010),
                  NOP_INSTR, NOP_INSTR, NOP_INSTR, NOP_INSTR};
         pushStore(vecs[v].name, 32'h10, vecs[v].expected, DS_WORD);
         applyStimulus(prog);
         runCycles(20, holds, stores);
      end

      // Back-to-back forwarding with no bubbles
      prog = '{encI(OP_ADDI, 5'd1, 5'd0, 16'd5), encI(OP_ADDI, 5'd2, 5'd0, 16'd7),
               encR(F_ADD, 5'd3, 5'd1, 5'd2), encI(OP_SW, 5'd3, 5'd0, 16'h0000),
               NOP_INSTR, NOP_INSTR, NOP_INSTR, NOP_INSTR};
      pushStore("fwdSum", 32'h0, 32'd12, DS_WORD);
      applyStimulus(prog);
      runCycles(20, holds, stores);
      checkOutput("fwdNoStall", 32'(holds), 32'd0);

      // Load-use: one held PC cycle, then 2x the loaded word
      prog = '{encI(OP_LW, 5'd4, 5'd0, 16'h0000), encR(F_ADD, 5'd5, 5'd4, 5'd4),
               encI(OP_SW, 5'd5, 5'd0, 16'h0004),
               NOP_INSTR, NOP_INSTR, NOP_INSTR, NOP_INSTR, NOP_INSTR};
      pushStore("loadUse", 32'h4, 32'h01FE_2468, DS_WORD);
      applyStimulus(prog);
      runCycles(20, holds, stores);
      checkOutput("loadUseStalls", 32'(holds), 32'd1);

      // Sub-word stores present the right-justified rt value and their size
      prog = '{encI(OP_ADDI, 5'd1, 5'd0, 16'h01AB), encI(OP_SB, 5'd1, 5'd0, 16'h0005),
               encI(OP_SH, 5'd1, 5'd0, 16'h0006),
               NOP_INSTR, NOP_INSTR, NOP_INSTR, NOP_INSTR, NOP_INSTR};
      pushStore("sb", 32'h5, 32'h0000_01AB, DS_BYTE);
      pushStore("sh", 32'h6, 32'h0000_01AB, DS_HALF);
      applyStimulus(prog);
      runCycles(20, holds, stores);

      // Taken BNEZ: the two fall-through stores are squashed
      prog = '{encI(OP_ADDI, 5'd1, 5'd0, 16'd5), encI(OP_BNEZ, 5'd0, 5'd1, 16'd8),
               encI(OP_SW, 5'd1, 5'd0, 16'h0010), encI(OP_SW, 5'd1, 5'd0, 16'h0014),
               encI(OP_ADDI, 5'd6, 5'd0, 16'h0055), encI(OP_SW, 5'd6, 5'd0, 16'h0018),
               NOP_INSTR, NOP_INSTR};
      pushStore("bnezTarget", 32'h18, 32'h55, DS_WORD);
      applyStimulus(prog);
      runCycles(25, holds, stores);

      // Untaken BEQZ: both following stores execute
      prog = '{encI(OP_ADDI, 5'd1, 5'd0, 16'd5), encI(OP_BEQZ, 5'd0, 5'd1, 16'd8),
               encI(OP_SW, 5'd1, 5'd0, 16'h0010), encI(OP_SW, 5'd1, 5'd0, 16'h0014),
               NOP_INSTR, NOP_INSTR, NOP_INSTR, NOP_INSTR};
      pushStore("beqzFall0", 32'h10, 32'd5, DS_WORD);
      pushStore("beqzFall1", 32'h14, 32'd5, DS_WORD);
      applyStimulus(prog);
      runCycles(25, holds, stores);

      // J skips exactly one instruction
      prog = '{encI(OP_ADDI, 5'd1, 5'd0, 16'd5), encJ(26'd4),
               encI(OP_SW, 5'd1, 5'd0, 16'h0020), encI(OP_SW, 5'd1, 5'd0, 16'h0024),
               NOP_INSTR, NOP_INSTR, NOP_INSTR, NOP_INSTR};
      pushStore("jTarget", 32'h24, 32'd5, DS_WORD);
      applyStimulus(prog);
      runCycles(25, holds, stores);

      // Reset asserted while a store sits in MEM
      prog = '{encI(OP_ADDI, 5'd1, 5'd0, 16'd5), encI(OP_SW, 5'd1, 5'd0, 16'h0000),
               NOP_INSTR, NOP_INSTR, NOP_INSTR, NOP_INSTR, NOP_INSTR, NOP_INSTR};
      applyStimulus(prog);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (memWr) found = 1'b1;
      end
      checkOutput("storeReachedMem", {31'h0, found}, 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("midResetPc",     currentAddress, 32'h0);
      checkOutput("midResetMemWr",  {31'h0, memWr}, 32'h0);
      checkOutput("midResetSize",   {30'h0, dataSize}, {30'h0, DS_WORD});
      checkOutput("midResetAluRes", aluResultMem, 32'h0);
      checkOutput("midResetBusB",   busBMem2, 32'h0);
      for (int i = 0; i < 64; i++) imem[i] = NOP_INSTR;
      @(negedge clk);
      rst_n = 1'b1;
      runCycles(20, holds, stores);
      checkOutput("postResetStores", 32'(stores), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
